// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue/capture/writeback sequencer driving a combinational ALU from an 8-entry register file.
// Defining ALU_IMM_EN adds in_imm_sel/in_imm so operand B can come from an immediate latched at accept.
module alu_issue_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int REG_COUNT = 8,
    parameter int CTRL_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
`ifdef ALU_IMM_EN
    input  logic              in_imm_sel,
    input  logic [DATA_W-1:0] in_imm,
`endif
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WRITEBACK} state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [CTRL_W-1:0] op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
`ifdef ALU_IMM_EN
    logic              imm_sel_q;
    logic [DATA_W-1:0] imm_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
`ifdef ALU_IMM_EN
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
`endif
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // The writeback assignment below comes later, so it overrides a load to the same register.
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        rd_q     <= in_rd;
                        rs1_q    <= in_rs1;
                        rs2_q    <= in_rs2;
`ifdef ALU_IMM_EN
                        imm_sel_q <= in_imm_sel;
                        imm_q     <= in_imm;
`endif
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_a    <= regs[rs1_q];
`ifdef ALU_IMM_EN
                    alu_b    <= imm_sel_q ? imm_q : regs[rs2_q];
`else
                    alu_b    <= regs[rs2_q];
`endif
                    alu_ctrl <= op_q;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    wb_data  <= alu_result;
                    flag_z   <= (alu_result == '0);
                    flag_n   <= alu_result[DATA_W-1];
                    wb_addr  <= rd_q;
                    wb_valid <= 1'b1;
                    state    <= WRITEBACK;
                end
                WRITEBACK: begin
                    regs[rd_q] <= wb_data;
                    wb_valid   <= 1'b0;
                    in_ready   <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed plan steps then random traffic against a stage-counting reference model.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op, in_rd, in_rs1, in_rs2;
`ifdef ALU_IMM_EN
    logic        in_imm_sel;
    logic [15:0] in_imm;
`endif
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flag_z, flag_n, busy;

    int checks = 0;
    int passes = 0;

    // Reference model: stage counts cycles since accept (0 = idle).
    int          stage;
    logic [15:0] m_regs [8];
    logic [2:0]  q_op, q_rd, q_rs1, q_rs2;
    logic        q_imm_sel;
    logic [15:0] q_imm;
    logic [15:0] m_a, m_b, m_res;
    logic [2:0]  m_ctrl;
    logic        m_z, m_n;
    logic [15:0] last_wb;
    logic        last_z, last_n;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
`ifdef ALU_IMM_EN
        .in_imm_sel(in_imm_sel), .in_imm(in_imm),
`endif
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_z(flag_z), .flag_n(flag_n), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[3:0];
            3'd6:    return a;
            default: return b;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_ctrl);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        stage = 0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_a = '0; m_b = '0; m_ctrl = '0; m_res = '0; m_z = 1'b0; m_n = 1'b0;
        q_op = '0; q_rd = '0; q_rs1 = '0; q_rs2 = '0; q_imm_sel = 1'b0; q_imm = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [15:0] nregs [8];
        int nstage;
        nregs  = m_regs;
        nstage = stage;
        if (ld_en) nregs[ld_addr] = ld_data;
        if (stage == 0) begin
            if (in_valid) begin
                q_op = in_op; q_rd = in_rd; q_rs1 = in_rs1; q_rs2 = in_rs2;
`ifdef ALU_IMM_EN
                q_imm_sel = in_imm_sel; q_imm = in_imm;
`endif
                nstage = 1;
            end
        end else if (stage == 1) begin
            m_a    = m_regs[q_rs1];
            m_b    = q_imm_sel ? q_imm : m_regs[q_rs2];
            m_ctrl = q_op;
            nstage = 2;
        end else if (stage == 2) begin
            m_res  = alu_fn(m_a, m_b, m_ctrl);
            m_z    = (m_res == 16'h0000);
            m_n    = m_res[15];
            nstage = 3;
        end else begin
            nregs[q_rd] = m_res;
            nstage = 0;
        end
        m_regs = nregs;
        stage  = nstage;
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, stage == 0);
        chk("busy", busy, stage != 0);
        chk("wb_valid", wb_valid, stage == 3);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_ctrl", alu_ctrl, m_ctrl);
        chk("flag_z", flag_z, m_z);
        chk("flag_n", flag_n, m_n);
        if (stage == 3) begin
            chk("wb_addr", wb_addr, q_rd);
            chk("wb_data", wb_data, m_res);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        #1;
        check_outputs();
        chk("rst_wb_addr", wb_addr, 3'd0);
        chk("rst_wb_data", wb_data, 16'h0000);
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        cycle();
        ld_en = 1'b0;
    endtask

    // Issues one op from IDLE and returns in the writeback cycle.
    task automatic run_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input string tag);
        int lat;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!wb_valid && lat < 8) begin
            cycle();
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        last_wb = wb_data; last_z = flag_z; last_n = flag_n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse, first, second;
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
`ifdef ALU_IMM_EN
        in_imm_sel = 1'b0; in_imm = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        async_reset();

        // 1: cleared registers read back as zero
        run_op(3'd0, 3'd0, 3'd0, 3'd0, "t1");
        chk("t1_wb_data", last_wb, 16'h0000);
        chk("t1_flag_z", last_z, 1'b1);
        cycle();

        // 2: negative operands
        load(3'd1, 16'hFFF1);
        load(3'd2, 16'hFFF4);
        run_op(3'd0, 3'd3, 3'd1, 3'd2, "t2");
        chk("t2_alu_a", alu_a, 16'hFFF1);
        chk("t2_alu_b", alu_b, 16'hFFF4);
        chk("t2_wb_data", last_wb, 16'hFFE5);
        chk("t2_flag_n", last_n, 1'b1);
        chk("t2_flag_z", last_z, 1'b0);
        cycle();

        // 3: in_valid held high only accepted in IDLE
        in_valid = 1'b1; in_op = 3'd0; in_rd = 3'd4; in_rs1 = 3'd3; in_rs2 = 3'd1;
        npulse = 0; first = -1; second = -1;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) in_valid = 1'b0;
            cycle();
            if (wb_valid) begin
                if (npulse == 0) first = c; else second = c;
                npulse++;
            end
        end
        chk("t3_pulses", npulse, 2);
        chk("t3_spacing", second - first, 4);

        // 4: load collides with writeback, then load to a different register
        run_op(3'd0, 3'd3, 3'd1, 3'd2, "t4a");
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'h1234;
        cycle();
        ld_en = 1'b0;
        run_op(3'd6, 3'd5, 3'd3, 3'd0, "t4b");
        chk("t4_r3_wb_wins", last_wb, 16'hFFE5);
        cycle();
        run_op(3'd1, 3'd3, 3'd1, 3'd2, "t4c");
        ld_en = 1'b1; ld_addr = 3'd4; ld_data = 16'h00AB;
        cycle();
        ld_en = 1'b0;
        run_op(3'd6, 3'd5, 3'd3, 3'd0, "t4d");
        chk("t4_r3_result", last_wb, 16'hFFFD);
        cycle();
        run_op(3'd6, 3'd5, 3'd4, 3'd0, "t4e");
        chk("t4_r4_load", last_wb, 16'h00AB);
        cycle();

        // 5: reset during CAPTURE drops the op
        in_valid = 1'b1; in_op = 3'd0; in_rd = 3'd6; in_rs1 = 3'd1; in_rs2 = 3'd2;
        cycle();
        in_valid = 1'b0;
        cycle();
        async_reset();
        repeat (4) cycle();
        run_op(3'd0, 3'd7, 3'd1, 3'd2, "t5");
        chk("t5_wb_data", last_wb, 16'h0000);
        chk("t5_flag_z", last_z, 1'b1);
        cycle();

`ifdef ALU_IMM_EN
        // 6: immediate operand B
        load(3'd1, 16'h0009);
        in_imm = 16'h0008; in_imm_sel = 1'b1;
        run_op(3'd0, 3'd2, 3'd1, 3'd5, "t6");
        chk("t6_alu_b", alu_b, 16'h0008);
        chk("t6_wb_data", last_wb, 16'h0011);
        in_imm_sel = 1'b0;
        cycle();
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_op = 3'($urandom); in_rd = 3'($urandom); in_rs1 = 3'($urandom); in_rs2 = 3'($urandom);
            ld_en = ($urandom_range(0, 3) == 0);
            ld_addr = 3'($urandom); ld_data = 16'($urandom);
`ifdef ALU_IMM_EN
            in_imm_sel = $urandom_range(0, 1) == 1; in_imm = 16'($urandom);
`endif
            if ($urandom_range(0, 99) == 0) async_reset();
            cycle();
        end
        in_valid = 1'b0; ld_en = 1'b0;
        repeat (4) cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle operand issue / writeback sequencer. It is the driving end of the combinational `alu` interface (`A`, `B`, `aluControl` in, `aluout` out).
- Accepts decoded ALU operations over a valid/ready handshake and reads operands from an internal register file.
- Drives registered operands and control to the ALU, captures `aluout`, writes the result back and updates Z/N flags.
- Sits between the decode stage and `alu` in the 16-bit single-core datapath.

Parameters:
- DATA_W, 16, operand/result width; matches `alu` A/B/aluout.
- ADDR_W, 3, register address width.
- REG_COUNT, 8, number of registers; must equal 2**ADDR_W.
- CTRL_W, 3, ALU control width; matches `aluControl`.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  decoded op present.
- in_ready  output  1  block can accept an op; high only in IDLE.
- in_op  input  CTRL_W  ALU control code.
- in_rd  input  ADDR_W  destination register.
- in_rs1  input  ADDR_W  source register for A.
- in_rs2  input  ADDR_W  source register for B.
- ld_en  input  1  external register load strobe.
- ld_addr  input  ADDR_W  load address.
- ld_data  input  DATA_W  load data.
- alu_a  output  DATA_W  to `alu.A`.
- alu_b  output  DATA_W  to `alu.B`.
- alu_ctrl  output  CTRL_W  to `alu.aluControl`.
- alu_result  input  DATA_W  from `alu.aluout`.
- wb_valid  output  1  one-cycle writeback pulse.
- wb_addr  output  ADDR_W  writeback register.
- wb_data  output  DATA_W  writeback value.
- flag_z  output  1  last result == 0.
- flag_n  output  1  last result MSB.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State goes to IDLE; in-flight op is discarded and never written back.
  - All registers are cleared to 0.
  - alu_a, alu_b, alu_ctrl, wb_addr, wb_data are 0; wb_valid, flag_z, flag_n, busy are 0; in_ready is 1 after reset deasserts.
- FSM: IDLE -> ISSUE -> CAPTURE -> WRITEBACK -> IDLE. Each non-IDLE state lasts exactly 1 cycle.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch op/rd/rs1/rs2 and go to ISSUE.
  - in_valid=0: stay in IDLE.
- ISSUE: at the end edge, alu_a<=reg[rs1], alu_b<=reg[rs2], alu_ctrl<=op.
  - Reads return contents before that edge; an ld_en write on the same edge is not visible.
- CAPTURE:
  - ALU inputs are stable for the whole cycle.
  - At the end edge, the result register <= alu_result, flag_z <= (alu_result==0), flag_n <= alu_result[DATA_W-1].
- WRITEBACK:
  - wb_valid=1, wb_addr=rd, wb_data=captured result.
  - reg[rd] is written at the end edge.
- Timing:
  - Latency from accept edge to wb_valid high is 3 cycles.
  - Throughput is 1 op per 4 cycles; a new accept is possible on the first IDLE cycle after WRITEBACK.
- Operand hold: alu_a/alu_b/alu_ctrl hold their last values outside ISSUE/CAPTURE (no glitching to 0).
- Flags update only in CAPTURE; they hold otherwise.
- Arithmetic: none internally; the result is the raw DATA_W `aluout`. No sign/zero extension.
- ld_en:
  - Accepted in any state; writes reg[ld_addr] at the edge.
  - If ld_en and a writeback target the same address on the same edge, the writeback wins and the load is dropped.
  - Different addresses are both written.
- in_valid while busy is ignored; in_ready=0 is the only backpressure. Upstream must hold its fields until accepted.
- rd == rs1 == rs2 is legal; sources are read before the writeback.

Optional Feature:
- Macro: ALU_IMM_EN.
- When defined, two extra ports exist:
  - in_imm_sel (input, 1).
  - in_imm (input, DATA_W).
- Both are latched at accept. In ISSUE, alu_b <= in_imm if in_imm_sel=1, else reg[rs2].
- When undefined, the ports are absent and alu_b is always reg[rs2].

Test Plan:
1. Reset then idle -> all outputs 0, in_ready=1, busy=0; regs read back 0 via an op with ctrl 3'b000 (add) giving wb_data=0x0000, flag_z=1.
2. ld r1=0xFFF1 (-15), r2=0xFFF4 (-12); op add rd=3, rs1=1, rs2=2 -> alu_a=0xFFF1, alu_b=0xFFF4 in CAPTURE; wb_valid exactly 3 cycles after accept, wb_data=0xFFE5, flag_n=1, flag_z=0.
3. Second op driven with in_valid=1 continuously during ops -> only accepted in IDLE; exactly 2 wb_valid pulses, each 4 cycles apart.
4. ld_en to r3 on the same edge as writeback to r3 -> r3 holds the ALU result; repeat with ld_addr=4 -> both r3 and r4 are updated.
5. Assert reset during CAPTURE -> no wb_valid; all regs 0; the next op accepted normally.
6. With ALU_IMM_EN: r1=9, in_imm=8, in_imm_sel=1 -> alu_b=0x0008, wb_data=0x0011 for add.
